branch_hazard_ctrl: RTL and testbench

//  Sequences the ID-stage branch unit. Detects operands not yet forwardable (load-use),

---
 rtl/branch_hazard_ctrl_pkg.sv | 20 ++
 rtl/bhc_hazard_detect.sv | 54 +++++
 rtl/branch_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage branch hazard controller.
//   bhc_state_e   : controller states (idle, load-use stall, pending redirect)
//   BHC_NUM_SRC   : number of register operands an ID instruction can read
//   BHC_NUM_CNT   : number of performance counters kept by the controller
//   BHC_CNT_TAKEN : counter slot for issued redirects
//   BHC_CNT_STALL : counter slot for stall cycles
package branch_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        BHC_IDLE  = 2'd0,
        BHC_STALL = 2'd1,
        BHC_PEND  = 2'd2
    } bhc_state_e;

    localparam int unsigned BHC_NUM_SRC   = 2;
    localparam int unsigned BHC_NUM_CNT   = 2;
    localparam int unsigned BHC_CNT_TAKEN = 0;
    localparam int unsigned BHC_CNT_STALL = 1;

endpackage

// File: rtl/bhc_hazard_detect.sv
// Pure combinational load-use hazard compare for a control-flow instruction in ID.
// A hazard exists when a read operand (other than x0) is produced by a load
// that is still in EX or MEM. Non-load producers are covered by forwarding.
// Ports:
//   id_valid_i, id_is_cf_i       : ID holds a valid JAL/JALR/Bxx
//   id_rs1_re_i, id_rs2_re_i     : operand read enables
//   id_rs1_i, id_rs2_i           : operand register addresses
//   ex_rd_i, ex_we_i, ex_is_load_i    : EX-stage producer info
//   mem_rd_i, mem_we_i, mem_is_load_i : MEM-stage producer info
//   hz_o                         : operands not yet forwardable
module bhc_hazard_detect
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            id_valid_i,
    input  logic            id_is_cf_i,
    input  logic            id_rs1_re_i,
    input  logic            id_rs2_re_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic            ex_we_i,
    input  logic            ex_is_load_i,
    input  logic [RA_W-1:0] mem_rd_i,
    input  logic            mem_we_i,
    input  logic            mem_is_load_i,
    output logic            hz_o
);

    logic [BHC_NUM_SRC-1:0] src_re;
    logic [RA_W-1:0]        src_ra [BHC_NUM_SRC];
    logic [BHC_NUM_SRC-1:0] src_hz;

    assign src_re[0] = id_rs1_re_i;
    assign src_re[1] = id_rs2_re_i;
    assign src_ra[0] = id_rs1_i;
    assign src_ra[1] = id_rs2_i;

    generate
        for (genvar gi = 0; gi < BHC_NUM_SRC; gi++) begin : g_src
            logic ex_match;
            logic mem_match;

            assign ex_match  = ex_we_i  & ex_is_load_i  & (ex_rd_i  == src_ra[gi]);
            assign mem_match = mem_we_i & mem_is_load_i & (mem_rd_i == src_ra[gi]);
            // x0 is hard-wired zero, so a load "writing" it never blocks a read.
            assign src_hz[gi] = src_re[gi] & (src_ra[gi] != '0) & (ex_match | mem_match);
        end
    endgenerate

    assign hz_o = id_valid_i & id_is_cf_i & (|src_hz);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencer. Stalls IF/ID on load-use hazards against a branch's
// operands, turns a resolved taken branch into an IF PC write plus IF/ID flush,
// and holds the target while IF is not ready to accept it.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_*                     : ID instruction info (valid, control-flow, operands)
//   ex_*, mem_*              : EX/MEM producer info for hazard detection
//   bu_pc, bu_pc_we          : branch unit target and taken flag
//   if_ready                 : IF accepts a PC write this cycle
//   pc_o, pc_we              : redirect target and strobe to IF
//   stall_if, stall_id       : hold PC and IF/ID registers
//   flush_id                 : bubble IF/ID (wrong-path fetch)
//   bubble_ex                : insert NOP into ID/EX
//   taken_cnt, stall_cnt     : saturating performance counters
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_is_cf,
    input  logic              id_rs1_re,
    input  logic              id_rs2_re,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic              mem_we,
    input  logic              mem_is_load,
    input  logic [ADDR_W-1:0] bu_pc,
    input  logic              bu_pc_we,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_we,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    bhc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              hz;
    logic              taken;

    bhc_hazard_detect #(
        .RA_W (RA_W)
    ) u_hazard_detect (
        .id_valid_i    (id_valid),
        .id_is_cf_i    (id_is_cf),
        .id_rs1_re_i   (id_rs1_re),
        .id_rs2_re_i   (id_rs2_re),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .ex_rd_i       (ex_rd),
        .ex_we_i       (ex_we),
        .ex_is_load_i  (ex_is_load),
        .mem_rd_i      (mem_rd),
        .mem_we_i      (mem_we),
        .mem_is_load_i (mem_is_load),
        .hz_o          (hz)
    );

    assign taken = id_valid & id_is_cf & bu_pc_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BHC_IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        pc_o      = '0;
        pc_we     = 1'b0;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;

        // Outputs are forced quiet while reset is held so a pending redirect
        // cannot leak out during the reset cycle.
        if (!rst) begin
            unique case (state_q)
                // STALL behaves exactly like IDLE once the hazard clears, so
                // both share the same decision; the hazard always wins.
                BHC_IDLE, BHC_STALL: begin
                    if (hz) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        state_d   = BHC_STALL;
                    end else if (taken && if_ready) begin
                        pc_o     = bu_pc;
                        pc_we    = 1'b1;
                        flush_id = 1'b1;
                        state_d  = BHC_IDLE;
                    end else if (taken) begin
                        target_d  = bu_pc;
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        state_d   = BHC_PEND;
                    end else begin
                        state_d = BHC_IDLE;
                    end
                end
                BHC_PEND: begin
                    pc_o      = target_q;
                    pc_we     = 1'b1;
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (if_ready) begin
                        flush_id = 1'b1;
                        state_d  = BHC_IDLE;
                    end
                end
                default: state_d = BHC_IDLE;
            endcase
        end
    end

    // Saturating counters. A stall cycle is any cycle stall_if is raised: this
    // covers the entry cycle into STALL/PEND and every PEND cycle, but not the
    // STALL cycle in which the hazard has already cleared.
    logic [BHC_NUM_CNT-1:0]            cnt_inc;
    logic [BHC_NUM_CNT-1:0][CNT_W-1:0] cnt_val;

    assign cnt_inc[BHC_CNT_TAKEN] = pc_we & if_ready;
    assign cnt_inc[BHC_CNT_STALL] = stall_if;

    generate
        for (genvar gi = 0; gi < BHC_NUM_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    assign taken_cnt = cnt_val[BHC_CNT_TAKEN];
    assign stall_cnt = cnt_val[BHC_CNT_STALL];

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

    localparam int ADDR_W = 32;
    localparam int RA_W   = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_is_cf, id_rs1_re, id_rs2_re;
    logic [RA_W-1:0]   id_rs1, id_rs2, ex_rd, mem_rd;
    logic              ex_we, ex_is_load, mem_we, mem_is_load;
    logic [ADDR_W-1:0] bu_pc;
    logic              bu_pc_we, if_ready;
    logic [ADDR_W-1:0] pc_o;
    logic              pc_we, stall_if, stall_id, flush_id, bubble_ex;
    logic [CNT_W-1:0]  taken_cnt, stall_cnt;
    logic [4:0]        ctl;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_hazard_ctrl #(
        .ADDR_W (ADDR_W),
        .RA_W   (RA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_is_cf    (id_is_cf),
        .id_rs1_re   (id_rs1_re),
        .id_rs2_re   (id_rs2_re),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .ex_is_load  (ex_is_load),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_is_load (mem_is_load),
        .bu_pc       (bu_pc),
        .bu_pc_we    (bu_pc_we),
        .if_ready    (if_ready),
        .pc_o        (pc_o),
        .pc_we       (pc_we),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .flush_id    (flush_id),
        .bubble_ex   (bubble_ex),
        .taken_cnt   (taken_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // {pc_we, stall_if, stall_id, flush_id, bubble_ex}
    assign ctl = {pc_we, stall_if, stall_id, flush_id, bubble_ex};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic out_chk(input string tag, input logic [4:0] e_ctl, input logic [ADDR_W-1:0] e_pc);
        #2;
        chk({tag, "_ctl"}, 64'(ctl), 64'(e_ctl));
        chk({tag, "_pc"}, 64'(pc_o), 64'(e_pc));
        $display("step %s: ctl=%b pc_o=0x%0h taken_cnt=%0d stall_cnt=%0d",
                 tag, ctl, pc_o, taken_cnt, stall_cnt);
    endtask

    task automatic cnt_chk(input string tag, input int e_taken, input int e_stall);
        chk({tag, "_taken_cnt"}, 64'(taken_cnt), 64'(e_taken));
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(e_stall));
    endtask

    task automatic clear_in();
        id_valid = 0; id_is_cf = 0; id_rs1_re = 0; id_rs2_re = 0;
        id_rs1 = '0; id_rs2 = '0;
        ex_rd = '0; ex_we = 0; ex_is_load = 0;
        mem_rd = '0; mem_we = 0; mem_is_load = 0;
        bu_pc = '0; bu_pc_we = 0; if_ready = 1;
    endtask

    task automatic branch(input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                          input logic tk, input logic [ADDR_W-1:0] tgt);
        id_valid = 1; id_is_cf = 1;
        id_rs1_re = 1; id_rs2_re = 1; id_rs1 = rs1; id_rs2 = rs2;
        bu_pc_we = tk; bu_pc = tgt;
    endtask

    initial begin
        // Reset
        rst = 1;
        clear_in();
        branch(5'd1, 5'd2, 1'b1, 32'h55);
        tick();
        out_chk("rst_hold", 5'b00000, 32'h0);
        tick();
        cnt_chk("rst_hold", 0, 0);
        rst = 0;
        clear_in();
        out_chk("reset_idle", 5'b00000, 32'h0);
        cnt_chk("reset_idle", 0, 0);
        tick();

        // 1: taken BEQ, no hazard, zero-cycle redirect
        branch(5'd3, 5'd4, 1'b1, 32'h100);
        out_chk("t1_redirect", 5'b10010, 32'h100);
        tick();
        cnt_chk("t1", 1, 0);
        clear_in();
        out_chk("t1_idle", 5'b00000, 32'h0);
        tick();

        // 2: LW x5 in EX, BNE rs1=x5; taken flag ignored while hazard
        branch(5'd5, 5'd0, 1'b1, 32'h200);
        ex_rd = 5'd5; ex_we = 1; ex_is_load = 1;
        out_chk("t2_stall1", 5'b01101, 32'h0);
        tick();
        cnt_chk("t2_stall1", 1, 1);
        ex_rd = '0; ex_we = 0; ex_is_load = 0;
        mem_rd = 5'd5; mem_we = 1; mem_is_load = 1;
        out_chk("t2_stall2", 5'b01101, 32'h0);
        tick();
        mem_rd = '0; mem_we = 0; mem_is_load = 0;
        out_chk("t2_resolve", 5'b10010, 32'h200);
        tick();
        cnt_chk("t2", 2, 2);
        clear_in();

        // 3: LW x5 in MEM, JALR rs1=x5 -> single stall cycle
        branch(5'd5, 5'd0, 1'b1, 32'h300);
        mem_rd = 5'd5; mem_we = 1; mem_is_load = 1;
        out_chk("t3_stall", 5'b01101, 32'h0);
        tick();
        mem_rd = '0; mem_we = 0; mem_is_load = 0;
        out_chk("t3_resolve", 5'b10010, 32'h300);
        tick();
        cnt_chk("t3", 3, 3);
        // x0 never hazards
        clear_in();
        branch(5'd0, 5'd0, 1'b0, 32'h0);
        ex_rd = 5'd0; ex_we = 1; ex_is_load = 1;
        out_chk("t3_x0", 5'b00000, 32'h0);
        tick();
        // non-load producer is forwarded: redirect immediately
        clear_in();
        branch(5'd0, 5'd7, 1'b1, 32'h400);
        ex_rd = 5'd7; ex_we = 1; ex_is_load = 0;
        out_chk("t3_fwd", 5'b10010, 32'h400);
        tick();
        cnt_chk("t3_fwd", 4, 3);
        // operand not read -> no hazard; then read via rs2 -> hazard
        clear_in();
        branch(5'd0, 5'd9, 1'b0, 32'h0);
        id_rs2_re = 0;
        ex_rd = 5'd9; ex_we = 1; ex_is_load = 1;
        out_chk("t3_rs2_unread", 5'b00000, 32'h0);
        tick();
        id_rs2_re = 1;
        out_chk("t3_rs2_hz", 5'b01101, 32'h0);
        tick();
        clear_in();
        out_chk("t3_stall_exit", 5'b00000, 32'h0);
        tick();
        cnt_chk("t3_end", 4, 4);

        // 4: JAL taken while IF busy; target held, flush only on accept
        branch(5'd0, 5'd0, 1'b1, 32'h2000);
        if_ready = 0;
        out_chk("t4_entry", 5'b01101, 32'h0);
        tick();
        bu_pc = 32'hDEAD;
        for (int k = 0; k < 3; k++) begin
            out_chk("t4_pend", 5'b11101, 32'h2000);
            tick();
        end
        cnt_chk("t4_pend", 4, 8);
        if_ready = 1;
        out_chk("t4_accept", 5'b11111, 32'h2000);
        tick();
        cnt_chk("t4", 5, 9);
        clear_in();
        out_chk("t4_idle", 5'b00000, 32'h0);
        tick();

        // 5: reset while in PEND drops the held target
        branch(5'd0, 5'd0, 1'b1, 32'h3000);
        if_ready = 0;
        out_chk("t5_entry", 5'b01101, 32'h0);
        tick();
        out_chk("t5_pend", 5'b11101, 32'h3000);
        tick();
        cnt_chk("t5_pre_rst", 5, 11);
        rst = 1;
        out_chk("t5_in_rst", 5'b00000, 32'h0);
        tick();
        rst = 0;
        clear_in();
        out_chk("t5_after_rst", 5'b00000, 32'h0);
        cnt_chk("t5_after_rst", 0, 0);
        tick();

        // 6: counter saturation (CNT_W=4)
        branch(5'd0, 5'd0, 1'b1, 32'h40);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t6_taken_sat", 64'(taken_cnt), 64'((i + 1 > 15) ? 15 : i + 1));
        end
        $display("step t6_taken: taken_cnt=%0d", taken_cnt);
        clear_in();
        branch(5'd6, 5'd0, 1'b0, 32'h0);
        ex_rd = 5'd6; ex_we = 1; ex_is_load = 1;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk("t6_stall_sat", 64'(stall_cnt), 64'((i + 1 > 15) ? 15 : i + 1));
        end
        $display("step t6_stall: stall_cnt=%0d", stall_cnt);
        clear_in();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
